router_fifo: RTL and testbench
==============================

# router_fifo

Per-destination packet FIFO of the 1x3 router. One instance sits on each output port, directly downstream of the router register stage. It stores header, payload and parity bytes tagged with a header marker and presents them to the destination on read. It tracks packet length from the header so that the output data bus returns to idle once a whole packet has been read.

## Interface
- DEPTH, 16, number of entries; power of two, at least 4.
- WIDTH, 8, data byte width; the stored entry is WIDTH+1 bits (header flag plus byte).
- clock  input  1  system clock; all state updates on the rising edge.
- resetn  input  1  reset, synchronous, active-low.
- soft_reset  input  1  synchronous, active-high flush for a destination timeout; same effect as resetn.
- write_enb  input  1  write request from the synchronizer for this port.
- read_enb  input  1  read request from the destination.
- lfd_state  input  1  FSM load-first-data indication; marks the byte written on the next write as a header.
- data_in  input  WIDTH  byte from the register stage.
- full  output  1  FIFO holds DEPTH entries; combinational from the pointers.
- empty  output  1  FIFO holds 0 entries; combinational from the pointers.
- data_out  output  WIDTH  registered read data; 0 when idle.

## Operation
- **Storage:** DEPTH x (WIDTH+1) array. Write and read pointers are each clog2(DEPTH)+1 bits; the MSB is the wrap bit.
  - empty is asserted when the pointers are equal.
  - full is asserted when the index bits are equal and the wrap bits differ.
- **Header tag:** lfd_state is registered as lfd_d. Each written entry is {lfd_d, data_in}. The header byte reaches data_in one cycle after lfd_state is asserted.
- **Write:** occurs when write_enb && !full. The entry is stored at wr_ptr and wr_ptr increments, wrapping naturally.
- **Read:** occurs when read_enb && !empty. data_out is loaded with mem[rd_ptr][WIDTH-1:0] and rd_ptr increments.
- **Packet counter** (7 bits, for WIDTH=8):
  - On a read whose entry has its flag set, count is loaded with data[7:2] + 1 (payload length plus parity byte).
  - On a read of an unflagged entry with count != 0, count decrements.
  - Count never underflows. An unflagged read with count == 0 still outputs the data.
- **Idle output:** on a cycle with no read and count == 0, data_out is set to 0. Otherwise data_out holds its value.
- **Simultaneous read and write:**
  - Both occur if the FIFO is neither full nor empty.
  - When full, the read occurs and the write is dropped, because full is sampled in the same cycle.
  - When empty, the write occurs and the read is ignored.
- **Writes while full:** dropped silently; there is no overwrite.
- **Reset or flush:** resetn low, or soft_reset high, in any cycle has the following effect, whichever is asserted and regardless of the other inputs:
  - Clears both pointers, count, lfd_d and data_out.
  - Array contents are don't-care.
  - Any packet in progress is discarded.

## Timing
- **Reset values:** full=0, empty=1, data_out=0.
- **Write to empty deasserting:** a write at edge N makes empty=0 after edge N.
- **Read latency:** one cycle. With read_enb high before edge N, data_out shows the byte after edge N.
- **full/empty update:** both update in the same cycle as the pointer edge.
- **Full throughput:** one write and one read per cycle sustained.
- **Idle return:** data_out returns to 0 one cycle after the read of the last (parity) byte of a packet, provided read_enb is low in that following cycle.
- **Back-to-back packets:** if a header is read in the cycle immediately after the parity byte, the counter reloads and data_out shows the new header. No idle cycle is inserted.

## Structure
- **Shared package router_pkg** holds:
  - the header field positions: address [1:0], length [7:2];
  - the length counter width;
  - the default DEPTH/WIDTH.
- **Sub-module router_pkt_counter:**
  - inputs: header flag, length field, read strobe;
  - outputs: count and a zero flag.
- Pointer and array logic stay in router_fifo.

## Test plan
- **Reset:** apply resetn=0 for 2 cycles -> empty=1, full=0, data_out=0.
- **Single packet:**
  - Stimulus: write header 8'h0D (length 3, addr 1) with lfd, then 3 payload bytes and parity 8'hA5, then read 5 times.
  - Required: data_out sequence 0D, p0, p1, p2, A5, then 00 on the next idle cycle; empty=1 after the fifth read.
- **Fill to full:**
  - Stimulus: 16 writes, then a 17th write of 8'hFF.
  - Required: full=1 after the 16th write; the 17th write is dropped; a subsequent drain reads exactly 16 bytes, none of them FF.
- **Simultaneous access:**
  - Stimulus: read and write together when full, and again when empty.
  - Required: when full, occupancy goes to 15; when empty, occupancy goes to 1 and data_out is unchanged.
- **Wrap-around:** push and pop 40 bytes with interleaved reads and writes -> all bytes come out in order; full and empty are correct across the pointer wrap.
- **Soft reset mid-packet:** assert soft_reset after 2 of 5 packet bytes have been read -> next cycle empty=1, data_out=0, count=0; a following new packet reads correctly.

Source files
------------

// File: rtl/router_pkg.sv
// Shared definitions for the 1x3 router: header field layout, packet counter width and the
// default FIFO geometry.
package router_pkg;

    localparam int unsigned DefDepth = 16;
    localparam int unsigned DefWidth = 8;

    // Header byte layout: destination address in [1:0], payload length in [7:2].
    localparam int unsigned AddrLsb  = 0;
    localparam int unsigned AddrMsb  = 1;
    localparam int unsigned LenLsb   = 2;
    localparam int unsigned LenMsb   = 7;
    localparam int unsigned LenWidth = LenMsb - LenLsb + 1;

    // One extra bit so that max length plus the parity byte still fits.
    localparam int unsigned CntWidth = LenWidth + 1;

    typedef logic [CntWidth-1:0] cnt_t;
    typedef logic [LenWidth-1:0] len_t;

    // Bytes still to be read after a header: payload plus parity.
    function automatic cnt_t pkt_remaining(input len_t len);
        return cnt_t'(len) + cnt_t'(1);
    endfunction

endpackage

// File: rtl/router_pkt_counter.sv
// Tracks how many bytes of the current packet remain to be read so that the FIFO output can
// return to idle once a whole packet has gone out.
module router_pkt_counter
    import router_pkg::*;
(
    input  logic clk_i,
    input  logic clr_i,
    input  logic rd_i,
    input  logic hdr_i,
    input  len_t len_i,
    output cnt_t count_o,
    output logic zero_o
);

    cnt_t count_q, count_d;

    assign zero_o  = (count_q == '0);
    assign count_o = count_q;

    always_comb begin
        count_d = count_q;
        if (rd_i) begin
            if (hdr_i) begin
                count_d = pkt_remaining(len_i);
            end else if (!zero_o) begin
                count_d = count_q - cnt_t'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/router_fifo.sv
// Per-destination packet FIFO: stores header-tagged bytes, presents them one cycle after a
// read request and drives an idle zero once the packet length counter has run out.
module router_fifo
    import router_pkg::*;
#(
    parameter int unsigned DEPTH = DefDepth,
    parameter int unsigned WIDTH = DefWidth
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             soft_reset,
    input  logic             write_enb,
    input  logic             read_enb,
    input  logic             lfd_state,
    input  logic [WIDTH-1:0] data_in,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] data_out
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef logic [AW:0]    ptr_t;
    typedef logic [WIDTH:0] entry_t;

    logic             clear;
    logic             do_wr;
    logic             do_rd;
    ptr_t             wr_ptr_q, wr_ptr_d;
    ptr_t             rd_ptr_q, rd_ptr_d;
    logic             lfd_q;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    entry_t           mem_q [DEPTH];
    entry_t           rd_entry;
    cnt_t             count;
    logic             count_zero;

    assign clear = !resetn || soft_reset;

    // Extra MSB on each pointer separates full from empty when the indices match.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

    assign do_wr    = write_enb && !full;
    assign do_rd    = read_enb && !empty;
    assign rd_entry = mem_q[rd_ptr_q[AW-1:0]];
    assign data_out = data_out_q;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        data_out_d = data_out_q;
        if (do_wr) begin
            wr_ptr_d = wr_ptr_q + ptr_t'(1);
        end
        if (do_rd) begin
            rd_ptr_d   = rd_ptr_q + ptr_t'(1);
            data_out_d = rd_entry[WIDTH-1:0];
        end else if (count_zero) begin
            data_out_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            lfd_q      <= 1'b0;
            data_out_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            lfd_q      <= lfd_state;
            data_out_q <= data_out_d;
        end
    end

    // Storage needs no reset; the cleared pointers make stale entries unreachable.
    always_ff @(posedge clock) begin
        if (do_wr) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {lfd_q, data_in};
        end
    end

    router_pkt_counter u_pkt_counter (
        .clk_i   (clock),
        .clr_i   (clear),
        .rd_i    (do_rd),
        .hdr_i   (rd_entry[WIDTH]),
        .len_i   (rd_entry[LenMsb:LenLsb]),
        .count_o (count),
        .zero_o  (count_zero)
    );

endmodule

// File: tb/tb_router_fifo.sv
// Self-checking bench for router_fifo against a queue-based packet model.
module tb_router_fifo;

    logic       clock;
    logic       resetn;
    logic       soft_reset;
    logic       write_enb;
    logic       read_enb;
    logic       lfd_state;
    logic [7:0] data_in;
    logic       full;
    logic       empty;
    logic [7:0] data_out;

    // Reference model state
    logic [8:0] mq[$];
    logic       m_lfd;
    int         m_cnt;
    logic [7:0] m_dout;

    int n_cmp;
    int n_bad;

    router_fifo #(.DEPTH(16), .WIDTH(8)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .soft_reset (soft_reset),
        .write_enb  (write_enb),
        .read_enb   (read_enb),
        .lfd_state  (lfd_state),
        .data_in    (data_in),
        .full       (full),
        .empty      (empty),
        .data_out   (data_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // One clock cycle of stimulus; the model advances on the same edge as the DUT.
    task automatic step(input logic we, input logic re, input logic lfd, input logic [7:0] din,
                        input logic rstn, input logic srst);
        logic [8:0] e;
        logic       rd_ok;
        logic       wr_ok;
        write_enb  = we;
        read_enb   = re;
        lfd_state  = lfd;
        data_in    = din;
        resetn     = rstn;
        soft_reset = srst;
        @(posedge clock);
        if (!rstn || srst) begin
            mq.delete();
            m_lfd  = 1'b0;
            m_cnt  = 0;
            m_dout = 8'h00;
        end else begin
            rd_ok = re && (mq.size() != 0);
            wr_ok = we && (mq.size() != 16);
            if (rd_ok) begin
                e      = mq.pop_front();
                m_dout = e[7:0];
                if (e[8]) m_cnt = int'(e[7:2]) + 1;
                else if (m_cnt > 0) m_cnt = m_cnt - 1;
            end else if (m_cnt == 0) begin
                m_dout = 8'h00;
            end
            if (wr_ok) mq.push_back({m_lfd, din});
            m_lfd = lfd;
        end
        #1;
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    // Header lands on the write after lfd_state, as the router FSM sequences it.
    task automatic write_pkt(input logic [7:0] b[$]);
        step(1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
        foreach (b[i]) step(1'b1, 1'b0, 1'b0, b[i], 1'b1, 1'b0);
    endtask

    task automatic test_reset();
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        n_cmp++;
        if (empty !== 1'b1) begin
            n_bad++; $display("FAIL reset_empty: got %b want 1", empty);
        end
        n_cmp++;
        if (full !== 1'b0) begin
            n_bad++; $display("FAIL reset_full: got %b want 0", full);
        end
        n_cmp++;
        if (data_out !== 8'h00) begin
            n_bad++; $display("FAIL reset_data_out: got %h want 00", data_out);
        end
    endtask

    task automatic test_single_packet();
        logic [7:0] pkt[$];
        do_reset();
        pkt = {8'h0D, 8'($urandom), 8'($urandom), 8'($urandom), 8'hA5};
        write_pkt(pkt);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
            n_cmp++;
            if (data_out !== pkt[i]) begin
                n_bad++; $display("FAIL single_byte%0d: got %h want %h", i, data_out, pkt[i]);
            end
        end
        n_cmp++;
        if (empty !== 1'b1) begin
            n_bad++; $display("FAIL single_empty: got %b want 1", empty);
        end
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        n_cmp++;
        if (data_out !== 8'h00) begin
            n_bad++; $display("FAIL single_idle: got %h want 00", data_out);
        end
    endtask

    task automatic test_fill_full();
        do_reset();
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b0, 8'(i + 1), 1'b1, 1'b0);
        n_cmp++;
        if (full !== 1'b1) begin
            n_bad++; $display("FAIL fill_full: got %b want 1", full);
        end
        step(1'b1, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b0);
        n_cmp++;
        if (full !== 1'b1 || empty !== 1'b0) begin
            n_bad++; $display("FAIL fill_17th: got full=%b empty=%b want full=1 empty=0",
                              full, empty);
        end
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
            n_cmp++;
            if (data_out !== 8'(i + 1)) begin
                n_bad++; $display("FAIL drain_byte%0d: got %h want %h", i, data_out, 8'(i + 1));
            end
        end
        n_cmp++;
        if (empty !== 1'b1) begin
            n_bad++; $display("FAIL drain_empty: got %b want 1", empty);
        end
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        n_cmp++;
        if (data_out !== 8'h00) begin
            n_bad++; $display("FAIL drain_extra: got %h want 00", data_out);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b0, 8'(8'h40 + i), 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 8'h77, 1'b1, 1'b0);
        n_cmp++;
        if (full !== 1'b0 || data_out !== 8'h40 || mq.size() != 15) begin
            n_bad++; $display("FAIL simul_full: got full=%b dout=%h want full=0 dout=40",
                              full, data_out);
        end
        for (int i = 1; i < 16; i++) begin
            step(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
            n_cmp++;
            if (data_out !== 8'(8'h40 + i)) begin
                n_bad++; $display("FAIL simul_drain%0d: got %h want %h", i, data_out,
                                  8'(8'h40 + i));
            end
        end
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b0);
        n_cmp++;
        if (empty !== 1'b0 || full !== 1'b0 || data_out !== 8'h00) begin
            n_bad++; $display("FAIL simul_empty: got empty=%b dout=%h want empty=0 dout=00",
                              empty, data_out);
        end
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        n_cmp++;
        if (data_out !== 8'h3C || empty !== 1'b1) begin
            n_bad++; $display("FAIL simul_single: got dout=%h empty=%b want 3c/1",
                              data_out, empty);
        end
    endtask

    task automatic test_wrap();
        int  pushed;
        int  cycles;
        logic we;
        logic re;
        do_reset();
        pushed = 0;
        cycles = 0;
        while ((pushed < 40 || mq.size() != 0) && cycles < 600) begin
            we = (pushed < 40) && ($urandom_range(0, 3) != 0);
            re = (pushed >= 40) || ($urandom_range(0, 2) == 0);
            if (we && mq.size() != 16) pushed++;
            step(we, re, 1'b0, 8'($urandom), 1'b1, 1'b0);
            cycles++;
            n_cmp++;
            if ({full, empty, data_out} !== {mq.size() == 16, mq.size() == 0, m_dout}) begin
                n_bad++;
                $display("FAIL wrap_cyc%0d: got full=%b empty=%b dout=%h want %b %b %h",
                         cycles, full, empty, data_out, mq.size() == 16, mq.size() == 0,
                         m_dout);
            end
        end
        n_cmp++;
        if (cycles >= 600) begin
            n_bad++; $display("FAIL wrap_budget: got %0d cycles want < 600", cycles);
        end
    endtask

    task automatic test_soft_reset();
        logic [7:0] a[$];
        logic [7:0] b[$];
        do_reset();
        a = {8'h0D, 8'h11, 8'h22, 8'h33, 8'h5A};
        b = {8'h09, 8'($urandom), 8'($urandom), 8'h6B};
        write_pkt(a);
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        n_cmp++;
        if (data_out !== 8'h11) begin
            n_bad++; $display("FAIL srst_pre: got %h want 11", data_out);
        end
        step(1'b1, 1'b1, 1'b1, 8'hEE, 1'b1, 1'b1);
        n_cmp++;
        if (empty !== 1'b1 || data_out !== 8'h00 || dut.u_pkt_counter.count_q !== 7'd0) begin
            n_bad++; $display("FAIL srst_clear: got empty=%b dout=%h cnt=%0d want 1/00/0",
                              empty, data_out, dut.u_pkt_counter.count_q);
        end
        write_pkt(b);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
            n_cmp++;
            if (data_out !== b[i]) begin
                n_bad++; $display("FAIL srst_post%0d: got %h want %h", i, data_out, b[i]);
            end
        end
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        n_cmp++;
        if (data_out !== 8'h00) begin
            n_bad++; $display("FAIL srst_idle: got %h want 00", data_out);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] a[$];
        logic [7:0] b[$];
        logic [7:0] all[$];
        do_reset();
        a = {8'h05, 8'($urandom), 8'h3E};
        b = {8'h06, 8'($urandom), 8'h4F};
        write_pkt(a);
        write_pkt(b);
        all = {a, b};
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
            n_cmp++;
            if (data_out !== all[i]) begin
                n_bad++; $display("FAIL b2b_byte%0d: got %h want %h", i, data_out, all[i]);
            end
        end
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        n_cmp++;
        if (data_out !== 8'h00) begin
            n_bad++; $display("FAIL b2b_idle: got %h want 00", data_out);
        end
    endtask

    task automatic test_random();
        logic srst;
        do_reset();
        for (int i = 0; i < 500; i++) begin
            srst = ($urandom_range(0, 63) == 0);
            step(1'($urandom), 1'($urandom), ($urandom_range(0, 5) == 0), 8'($urandom),
                 1'b1, srst);
            n_cmp++;
            if ({full, empty, data_out, dut.u_pkt_counter.count_q} !==
                {mq.size() == 16, mq.size() == 0, m_dout, 7'(m_cnt)}) begin
                n_bad++;
                $display("FAIL rand_cyc%0d: got full=%b empty=%b dout=%h cnt=%0d want %b %b %h %0d",
                         i, full, empty, data_out, dut.u_pkt_counter.count_q,
                         mq.size() == 16, mq.size() == 0, m_dout, m_cnt);
            end
        end
    endtask

    initial begin
        n_cmp      = 0;
        n_bad      = 0;
        m_lfd      = 1'b0;
        m_cnt      = 0;
        m_dout     = 8'h00;
        resetn     = 1'b0;
        soft_reset = 1'b0;
        write_enb  = 1'b0;
        read_enb   = 1'b0;
        lfd_state  = 1'b0;
        data_in    = 8'h00;
        test_reset();
        test_single_packet();
        test_fill_full();
        test_simultaneous();
        test_wrap();
        test_soft_reset();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
